// File: rtl/cert_chain_checker_if.sv
// Bundle of the control, chunk-stream, provisioning and result signals
// shared between the certificate chain checker and whoever drives it.
interface cert_chain_checker_if #(
    parameter int SLOTS      = 4,
    parameter int MAX_CHUNKS = 8,
    parameter int CHUNK_W    = 64
);
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int IDX_W  = (MAX_CHUNKS > 1) ? $clog2(MAX_CHUNKS) : 1;
    localparam int LEN_W  = $clog2(MAX_CHUNKS + 1);

    logic               Enable;
    logic               start;
    logic [SLOT_W-1:0]  slot;
    logic               chunk_valid;
    logic [CHUNK_W-1:0] chunk_data;
    logic               chunk_ready;
    logic               prov_we;
    logic               prov_len_we;
    logic [SLOT_W-1:0]  prov_slot;
    logic [IDX_W-1:0]   prov_idx;
    logic [CHUNK_W-1:0] prov_data;
    logic [LEN_W-1:0]   prov_len;
    logic               busy;
    logic               done;
    logic               Valid_Certificate;
    logic               Error_Invalid_Certificate;
    logic [1:0]         err_code;
    logic [IDX_W-1:0]   mismatch_idx;

    modport master (
        output Enable, start, slot, chunk_valid, chunk_data,
               prov_we, prov_len_we, prov_slot, prov_idx, prov_data, prov_len,
        input  chunk_ready, busy, done, Valid_Certificate,
               Error_Invalid_Certificate, err_code, mismatch_idx
    );

    modport slave (
        input  Enable, start, slot, chunk_valid, chunk_data,
               prov_we, prov_len_we, prov_slot, prov_idx, prov_data, prov_len,
        output chunk_ready, busy, done, Valid_Certificate,
               Error_Invalid_Certificate, err_code, mismatch_idx
    );
endinterface

// File: rtl/cert_chain_checker.sv
// Certificate chain checker: compares a streamed certificate, chunk by
// chunk, against a provisioned reference held in per-slot storage and
// reports pass/fail with the first mismatching chunk index.
module cert_chain_checker #(
    parameter int SLOTS      = 4,
    parameter int MAX_CHUNKS = 8,
    parameter int CHUNK_W    = 64,
    parameter int TIMEOUT    = 255
) (
    input logic               clk,
    input logic               Reset,
    cert_chain_checker_if.slave bus
);
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int IDX_W  = (MAX_CHUNKS > 1) ? $clog2(MAX_CHUNKS) : 1;
    localparam int LEN_W  = $clog2(MAX_CHUNKS + 1);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    localparam logic [SLOT_W:0]   SLOTS_EXT = (SLOT_W + 1)'(SLOTS);
    localparam logic [IDX_W:0]    CHUNKS_EXT = (IDX_W + 1)'(MAX_CHUNKS);
    localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_CHUNKS);
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    state_t             state;
    logic [CHUNK_W-1:0] mem [SLOTS][MAX_CHUNKS];
    logic [LEN_W-1:0]   len_tab [SLOTS];
    logic [SLOT_W-1:0]  cur_slot;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   idle_cnt;
    logic               mis_flag;
    logic               busy_q;
    logic               done_q;
    logic               valid_q;
    logic               error_q;
    logic [1:0]         err_code_q;
    logic [IDX_W-1:0]   mismatch_idx_q;

    logic               slot_in_range;
    logic [LEN_W-1:0]   start_len;
    logic               chunk_mismatch;
    logic               last_chunk;
    logic               timeout_hit;
    logic               prov_allowed;
    logic               prov_slot_ok;
    logic               prov_idx_ok;
    logic [LEN_W-1:0]   prov_len_sat;

    assign bus.chunk_ready               = (state == CHECK) && bus.Enable;
    assign bus.busy                      = busy_q;
    assign bus.done                      = done_q;
    assign bus.Valid_Certificate         = valid_q;
    assign bus.Error_Invalid_Certificate = error_q;
    assign bus.err_code                  = err_code_q;
    assign bus.mismatch_idx              = mismatch_idx_q;

    // Decode start legality, the current chunk comparison and the end-of-check conditions.
    always_comb begin
        slot_in_range  = ({1'b0, bus.slot} < SLOTS_EXT);
        start_len      = '0;
        if (slot_in_range) start_len = len_tab[bus.slot];
        chunk_mismatch = (bus.chunk_data != mem[cur_slot][idx]);
        last_chunk     = ((LEN_W'(idx) + LEN_W'(1)) == len_tab[cur_slot]);
        timeout_hit    = ((idle_cnt + CNT_W'(1)) == TIMEOUT_C);
        prov_allowed   = (state != CHECK);
        prov_slot_ok   = ({1'b0, bus.prov_slot} < SLOTS_EXT);
        prov_idx_ok    = ({1'b0, bus.prov_idx} < CHUNKS_EXT);
        prov_len_sat   = (bus.prov_len > MAX_LEN) ? MAX_LEN : bus.prov_len;
    end

    // Reference chunk storage; deliberately untouched by reset so provisioning survives it.
    always_ff @(posedge clk) begin
        if (bus.prov_we && prov_allowed && prov_slot_ok && prov_idx_ok)
            mem[bus.prov_slot][bus.prov_idx] <= bus.prov_data;
    end

    // Per-slot chunk counts; a zero count marks the slot as unprovisioned.
    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < SLOTS; i++) len_tab[i] <= '0;
        end else if (bus.prov_len_we && prov_allowed && prov_slot_ok) begin
            len_tab[bus.prov_slot] <= prov_len_sat;
        end
    end

    // Check sequencer with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state          <= IDLE;
            cur_slot       <= '0;
            idx            <= '0;
            idle_cnt       <= '0;
            mis_flag       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            valid_q        <= 1'b0;
            error_q        <= 1'b0;
            err_code_q     <= 2'd0;
            mismatch_idx_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Enable && bus.start) begin
                        valid_q        <= 1'b0;
                        error_q        <= 1'b0;
                        err_code_q     <= 2'd0;
                        mismatch_idx_q <= '0;
                        if (!slot_in_range || (start_len == '0)) begin
                            state      <= DONE;
                            done_q     <= 1'b1;
                            error_q    <= 1'b1;
                            err_code_q <= 2'd2;
                        end else begin
                            state    <= CHECK;
                            busy_q   <= 1'b1;
                            cur_slot <= bus.slot;
                            idx      <= '0;
                            idle_cnt <= '0;
                            mis_flag <= 1'b0;
                        end
                    end
                end
                CHECK: begin
                    if (bus.Enable) begin
                        if (bus.chunk_valid) begin
                            idle_cnt <= '0;
                            if (chunk_mismatch && !mis_flag) begin
                                mis_flag       <= 1'b1;
                                mismatch_idx_q <= idx;
                            end
                            if (last_chunk) begin
                                state  <= DONE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                if (mis_flag || chunk_mismatch) begin
                                    error_q    <= 1'b1;
                                    err_code_q <= 2'd1;
                                end else begin
                                    valid_q <= 1'b1;
                                end
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end else if (timeout_hit) begin
                            state      <= DONE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            error_q    <= 1'b1;
                            err_code_q <= 2'd3;
                            idle_cnt   <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cert_chain_checker.sv
// Scoreboard bench for cert_chain_checker: expected results are queued when
// a check is launched and compared whenever the DUT pulses done.
module tb_cert_chain_checker;
    localparam int SLOTS      = 3;
    localparam int MAX_CHUNKS = 4;
    localparam int CHUNK_W    = 16;
    localparam int TIMEOUT    = 4;

    localparam logic [15:0] CH_A = 16'hA1A1;
    localparam logic [15:0] CH_B = 16'hB2B2;
    localparam logic [15:0] CH_C = 16'hC3C3;
    localparam logic [15:0] CH_X = 16'h5A5A;
    localparam logic [15:0] CH_D0 = 16'h00D0;
    localparam logic [15:0] CH_D1 = 16'h00D1;

    typedef struct packed {
        logic       vc;
        logic       eic;
        logic [1:0] code;
        logic [1:0] midx;
    } exp_t;

    logic clk = 1'b0;
    logic Reset;

    exp_t        sb[$];
    int          assert_count = 0;
    int          fail_count   = 0;
    int          done_count   = 0;
    logic [15:0] model_mem [SLOTS][MAX_CHUNKS];
    int          model_len [SLOTS];

    always #5 clk = ~clk;

    cert_chain_checker_if #(.SLOTS(SLOTS), .MAX_CHUNKS(MAX_CHUNKS), .CHUNK_W(CHUNK_W)) bus ();

    cert_chain_checker #(
        .SLOTS(SLOTS), .MAX_CHUNKS(MAX_CHUNKS), .CHUNK_W(CHUNK_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .Reset(Reset),
        .bus  (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic exp_t mkExp(input logic vc, input logic eic, input logic [1:0] code, input logic [1:0] midx);
        exp_t e;
        e.vc = vc; e.eic = eic; e.code = code; e.midx = midx;
        return e;
    endfunction

    // Reference model of a fully delivered check against the provisioned tables.
    function automatic exp_t modelCheck(input int s, input logic [63:0] ch);
        exp_t e;
        logic mis;
        e = mkExp(1'b0, 1'b0, 2'd0, 2'd0);
        if (s >= SLOTS) return mkExp(1'b0, 1'b1, 2'd2, 2'd0);
        if (model_len[s] == 0) return mkExp(1'b0, 1'b1, 2'd2, 2'd0);
        mis = 1'b0;
        for (int i = 0; i < model_len[s]; i++) begin
            if (ch[16*i +: 16] != model_mem[s][i] && !mis) begin
                mis = 1'b1;
                e.midx = 2'(i);
            end
        end
        if (mis) begin e.eic = 1'b1; e.code = 2'd1; end
        else e.vc = 1'b1;
        return e;
    endfunction

    // Pops an expectation every time the DUT reports the end of a check.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.done === 1'b1) begin
            done_count++;
            if (sb.size() == 0) begin
                checkOutput("spurious_done", bus.done, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("sb_valid", bus.Valid_Certificate, e.vc);
                checkOutput("sb_error", bus.Error_Invalid_Certificate, e.eic);
                checkOutput("sb_err_code", bus.err_code, e.code);
                checkOutput("sb_mismatch_idx", bus.mismatch_idx, e.midx);
                checkOutput("sb_exclusive", bus.Valid_Certificate & bus.Error_Invalid_Certificate, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic provChunk(input int s, input int i, input logic [15:0] d);
        bus.prov_we   = 1'b1;
        bus.prov_slot = 2'(s);
        bus.prov_idx  = 2'(i);
        bus.prov_data = d;
        tick();
        bus.prov_we = 1'b0;
        if (s < SLOTS) model_mem[s][i] = d;
    endtask

    task automatic provLen(input int s, input int l);
        bus.prov_len_we = 1'b1;
        bus.prov_slot   = 2'(s);
        bus.prov_len    = 3'(l);
        tick();
        bus.prov_len_we = 1'b0;
        if (s < SLOTS) model_len[s] = (l > MAX_CHUNKS) ? MAX_CHUNKS : l;
    endtask

    task automatic startCheck(input int s);
        bus.start = 1'b1;
        bus.slot  = 2'(s);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] d);
        bus.chunk_valid = 1'b1;
        bus.chunk_data  = d;
        tick();
        bus.chunk_valid = 1'b0;
    endtask

    // mode 1: start pulsed mid-check, 2: provisioning write mid-check, 3: start held during DONE.
    task automatic runCheck(input int s, input logic [63:0] ch, input int mode);
        int n;
        sb.push_back(modelCheck(s, ch));
        n = model_len[s];
        startCheck(s);
        checkOutput("busy_after_start", bus.busy, 1);
        for (int i = 0; i < n; i++) begin
            if (i > 0) checkOutput("done_early", bus.done, 0);
            if (mode == 1 && i == 1) begin
                bus.start = 1'b1;
                bus.slot  = 2'd0;
            end
            if (mode == 2 && i == 1) begin
                bus.prov_we   = 1'b1;
                bus.prov_slot = 2'(s);
                bus.prov_idx  = 2'd2;
                bus.prov_data = ~model_mem[s][2];
            end
            applyStimulus(ch[16*i +: 16]);
            bus.start   = 1'b0;
            bus.prov_we = 1'b0;
        end
        checkOutput("done_after_last", bus.done, 1);
        checkOutput("busy_after_last", bus.busy, 0);
        if (mode == 3) begin
            bus.start = 1'b1;
            bus.slot  = 2'(s);
            tick();
            bus.start = 1'b0;
            tick();
            checkOutput("start_in_done_busy", bus.busy, 0);
            checkOutput("start_in_done_done", bus.done, 0);
        end else begin
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < SLOTS; i++) model_len[i] = 0;
        Reset           = 1'b1;
        bus.Enable      = 1'b1;
        bus.start       = 1'b0;
        bus.slot        = '0;
        bus.chunk_valid = 1'b0;
        bus.chunk_data  = '0;
        bus.prov_we     = 1'b0;
        bus.prov_len_we = 1'b0;
        bus.prov_slot   = '0;
        bus.prov_idx    = '0;
        bus.prov_data   = '0;
        bus.prov_len    = '0;
        repeat (3) tick();

        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_valid", bus.Valid_Certificate, 0);
        checkOutput("rst_error", bus.Error_Invalid_Certificate, 0);
        checkOutput("rst_err_code", bus.err_code, 0);
        checkOutput("rst_mismatch_idx", bus.mismatch_idx, 0);
        checkOutput("rst_ready", bus.chunk_ready, 0);
        Reset = 1'b0;
        tick();

        provChunk(1, 0, CH_A);
        provChunk(1, 1, CH_B);
        provChunk(1, 2, CH_C);
        provLen(1, 3);

        // Chunk write and length write to the same slot in one cycle.
        bus.prov_we     = 1'b1;
        bus.prov_len_we = 1'b1;
        bus.prov_slot   = 2'd0;
        bus.prov_idx    = 2'd0;
        bus.prov_data   = CH_D0;
        bus.prov_len    = 3'd1;
        tick();
        bus.prov_we     = 1'b0;
        bus.prov_len_we = 1'b0;
        model_mem[0][0] = CH_D0;
        model_len[0]    = 1;

        runCheck(1, {16'h0, CH_C, CH_B, CH_A}, 3);
        runCheck(1, {16'h0, CH_C, CH_X, CH_A}, 1);
        repeat (2) tick();
        checkOutput("held_error", bus.Error_Invalid_Certificate, 1);
        checkOutput("held_valid", bus.Valid_Certificate, 0);
        checkOutput("held_err_code", bus.err_code, 1);
        checkOutput("held_mismatch_idx", bus.mismatch_idx, 1);

        runCheck(0, {48'h0, CH_D0}, 0);

        sb.push_back(modelCheck(SLOTS, 64'h0));
        startCheck(SLOTS);
        checkOutput("badslot_busy", bus.busy, 0);
        checkOutput("badslot_done", bus.done, 1);
        tick();
        sb.push_back(modelCheck(2, 64'h0));
        startCheck(2);
        checkOutput("empty_busy", bus.busy, 0);
        checkOutput("empty_done", bus.done, 1);
        tick();

        provLen(2, 7);
        for (int i = 0; i < MAX_CHUNKS; i++) provChunk(2, i, 16'h2000 + 16'(i));
        runCheck(2, {16'h2003, 16'h2002, 16'h2001, 16'h2000}, 0);

        provLen(0, 2);
        provChunk(0, 1, CH_D1);

        sb.push_back(mkExp(1'b0, 1'b1, 2'd3, 2'd0));
        startCheck(0);
        applyStimulus(model_mem[0][0]);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            checkOutput("timeout_early", bus.done, 0);
        end
        tick();
        checkOutput("timeout_done", bus.done, 1);
        tick();

        sb.push_back(mkExp(1'b0, 1'b1, 2'd3, 2'd0));
        startCheck(0);
        applyStimulus(model_mem[0][0]);
        repeat (2) tick();
        bus.Enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("paused_ready", bus.chunk_ready, 0);
            checkOutput("paused_busy", bus.busy, 1);
        end
        bus.Enable = 1'b1;
        tick();
        checkOutput("resumed_early", bus.done, 0);
        tick();
        checkOutput("resumed_timeout_done", bus.done, 1);
        tick();

        sb.push_back(mkExp(1'b0, 1'b1, 2'd3, 2'd0));
        startCheck(0);
        applyStimulus(~model_mem[0][0]);
        repeat (TIMEOUT - 1) tick();
        tick();
        checkOutput("override_done", bus.done, 1);
        tick();

        startCheck(1);
        applyStimulus(model_mem[1][0]);
        Reset = 1'b1;
        tick();
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_done", bus.done, 0);
        checkOutput("abort_valid", bus.Valid_Certificate, 0);
        checkOutput("abort_error", bus.Error_Invalid_Certificate, 0);
        checkOutput("abort_err_code", bus.err_code, 0);
        checkOutput("abort_mismatch_idx", bus.mismatch_idx, 0);
        checkOutput("abort_ready", bus.chunk_ready, 0);
        Reset = 1'b0;
        for (int i = 0; i < SLOTS; i++) model_len[i] = 0;
        tick();

        sb.push_back(modelCheck(1, 64'h0));
        startCheck(1);
        checkOutput("len_cleared_done", bus.done, 1);
        tick();

        provLen(1, 3);
        runCheck(1, {16'h0, CH_C, CH_B, CH_A}, 2);

        repeat (3) tick();
        checkOutput("sb_empty", sb.size(), 0);
        checkOutput("done_total", done_count, 11);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
